// File: rtl/ext_bus_seq_if.sv
// Core-side request/response and pad-side signals of the external bus sequencer.
// master = core plus pad environment, slave = the sequencer itself.
interface ext_bus_seq_if;
  logic        cpu_req;
  logic [10:0] cpu_addr;
  logic        cpu_rnw;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [7:0]  pad_out;
  logic [7:0]  pad_uio_out;
  logic [7:0]  pad_uio_oe;
  logic [7:0]  pad_uio_in;

  modport master (
    output cpu_req, cpu_addr, cpu_rnw, cpu_wdata, pad_uio_in,
    input  cpu_rdata, cpu_ack, pad_out, pad_uio_out, pad_uio_oe
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_rnw, cpu_wdata, pad_uio_in,
    output cpu_rdata, cpu_ack, pad_out, pad_uio_out, pad_uio_oe
  );
endinterface

// File: rtl/ext_bus_seq.sv
// Multiplexes an 11-bit address / 8-bit data core bus onto 8 dedicated and 8 bidir pads.
// Optional BUS_TURNAROUND_EN inserts a bus-idle TURN cycle between ADDR and STRB on reads.
module ext_bus_seq #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic         clk,
  input logic         rst,
  ext_bus_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_TURN = 3'd2,
    S_STRB = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] addr_q, addr_d;
  logic        rnw_q, rnw_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic [7:0]  pad_out_q, pad_out_d;
  logic [7:0]  uio_out_q, uio_out_d;
  logic [7:0]  uio_oe_q, uio_oe_d;

  logic ale_s;
  logic rd_n_s;
  logic wr_n_s;
  logic busy_s;

  // Sequencing: state transitions, request capture, strobe counting and read capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rnw_d   = rnw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          state_d = S_ADDR;
          addr_d  = bus.cpu_addr;
          rnw_d   = bus.cpu_rnw;
          wdata_d = bus.cpu_wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
`ifdef BUS_TURNAROUND_EN
        if (rnw_q) begin
          state_d = S_TURN;
        end else begin
          state_d = S_STRB;
          cnt_d   = WAIT_INIT;
        end
`else
        state_d = S_STRB;
        cnt_d   = WAIT_INIT;
`endif
      end
      S_TURN: begin
        state_d = S_STRB;
        cnt_d   = WAIT_INIT;
      end
      S_STRB: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          // Sample the pads on the edge that ends the read strobe.
          if (rnw_q) begin
            rdata_d = bus.pad_uio_in;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pad/cpu output values for the upcoming state, so every output is a flop.
  always_comb begin
    ale_s     = 1'b0;
    rd_n_s    = 1'b1;
    wr_n_s    = 1'b1;
    busy_s    = 1'b1;
    ack_d     = 1'b0;
    uio_oe_d  = 8'h00;
    uio_out_d = 8'h00;
    case (state_d)
      S_IDLE: begin
        busy_s = 1'b0;
      end
      S_ADDR: begin
        ale_s     = 1'b1;
        uio_oe_d  = 8'hFF;
        uio_out_d = addr_d[7:0];
      end
      S_TURN: begin
        busy_s = 1'b1;
      end
      S_STRB: begin
        if (rnw_d) begin
          rd_n_s = 1'b0;
        end else begin
          wr_n_s    = 1'b0;
          uio_oe_d  = 8'hFF;
          uio_out_d = wdata_d;
        end
      end
      S_DONE: begin
        ack_d = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
    pad_out_d = {1'b0, busy_s, wr_n_s, rd_n_s, ale_s, addr_d[10:8]};
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 11'd0;
      rnw_q     <= 1'b0;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      ack_q     <= 1'b0;
      pad_out_q <= 8'h30;
      uio_out_q <= 8'h00;
      uio_oe_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rnw_q     <= rnw_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      pad_out_q <= pad_out_d;
      uio_out_q <= uio_out_d;
      uio_oe_q  <= uio_oe_d;
    end
  end

  assign bus.cpu_rdata   = rdata_q;
  assign bus.cpu_ack     = ack_q;
  assign bus.pad_out     = pad_out_q;
  assign bus.pad_uio_out = uio_out_q;
  assign bus.pad_uio_oe  = uio_oe_q;

endmodule

// File: tb/tb_ext_bus_seq.sv
// Directed bench for ext_bus_seq: stimulus pushes expected acks into a scoreboard,
// a negedge monitor pops and compares whenever cpu_ack is seen.
module tb_ext_bus_seq;
  localparam int WAIT   = 1;
  localparam int LAT_WR = WAIT + 3;
`ifdef BUS_TURNAROUND_EN
  localparam int LAT_RD = WAIT + 4;
`else
  localparam int LAT_RD = WAIT + 3;
`endif

  typedef struct {
    logic [7:0] rdata;
    int         ack_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] mem_val;
  logic [7:0] last_rd;
  exp_t sb_q[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc;

  ext_bus_seq_if bus();

  ext_bus_seq #(.WAIT_CYCLES(WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External memory: drives the read value only while RD_N is low.
  assign bus.pad_uio_in = bus.pad_out[4] ? 8'hA5 : mem_val;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      chk("strobe_overlap", {31'd0, (!bus.pad_out[4] && !bus.pad_out[5])}, 32'd0);
      if (bus.cpu_ack) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", {31'd0, bus.cpu_ack}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("ack_rdata", {24'd0, bus.cpu_rdata}, {24'd0, mon_e.rdata});
          chk("ack_cycle", cyc, mon_e.ack_cyc);
        end
      end
    end
  end

  task automatic issue(input logic [10:0] a, input logic rnw, input logic [7:0] wd,
                       input logic [7:0] rv, output int acc_o);
    exp_t e;
    @(posedge clk); #1;
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_rnw   = rnw;
    bus.cpu_wdata = wd;
    mem_val       = rv;
    acc_o = cyc + 1;
    if (rnw) last_rd = rv;
    e.rdata   = last_rd;
    e.ack_cyc = acc_o + (rnw ? LAT_RD : LAT_WR) - 1;
    sb_q.push_back(e);
  endtask

  task automatic finish_txn();
    int n = 0;
    while (!bus.cpu_ack && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ack_seen", {31'd0, bus.cpu_ack}, 32'd1);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic at_cyc(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_addr = 11'd0;
    bus.cpu_rnw = 1'b0;
    bus.cpu_wdata = 8'h00;
    mem_val = 8'h00;
    last_rd = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst_pad_out", bus.pad_out, 32'h30);
    chk("rst_oe", bus.pad_uio_oe, 32'h00);
    chk("rst_uio_out", bus.pad_uio_out, 32'h00);
    chk("rst_ack", bus.cpu_ack, 32'h0);
    chk("rst_rdata", bus.cpu_rdata, 32'h00);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_pad_out", bus.pad_out, 32'h30);
    chk("idle_oe", bus.pad_uio_oe, 32'h00);
    chk("idle_rdata", bus.cpu_rdata, 32'h00);

    // Write 5A3 <- C3; inputs scrambled after acceptance must be ignored.
    issue(11'h5A3, 1'b0, 8'hC3, 8'h00, acc);
    at_cyc(acc);
    bus.cpu_addr = 11'h0FF; bus.cpu_wdata = 8'h99; bus.cpu_rnw = 1'b1;
    chk("wr_addr_pad_out", bus.pad_out, 32'h7D);
    chk("wr_addr_uio", bus.pad_uio_out, 32'hA3);
    chk("wr_addr_oe", bus.pad_uio_oe, 32'hFF);
    for (int k = 1; k <= WAIT + 1; k++) begin
      at_cyc(acc + k);
      chk("wr_strb_pad_out", bus.pad_out, 32'h55);
      chk("wr_strb_uio", bus.pad_uio_out, 32'hC3);
      chk("wr_strb_oe", bus.pad_uio_oe, 32'hFF);
    end
    at_cyc(acc + LAT_WR - 1);
    chk("wr_done_oe", bus.pad_uio_oe, 32'h00);
    chk("wr_done_pad_out", bus.pad_out, 32'h75);
    finish_txn();
    @(negedge clk);
    chk("idle_hold_ahi", bus.pad_out, 32'h35);

    // Read 100 -> 7E
    issue(11'h100, 1'b1, 8'h00, 8'h7E, acc);
    at_cyc(acc);
    chk("rd_addr_pad_out", bus.pad_out, 32'h79);
    chk("rd_addr_uio", bus.pad_uio_out, 32'h00);
`ifdef BUS_TURNAROUND_EN
    at_cyc(acc + 1);
    chk("rd_turn_pad_out", bus.pad_out, 32'h71);
    chk("rd_turn_oe", bus.pad_uio_oe, 32'h00);
    at_cyc(acc + 2);
    chk("rd_strb_pad_out", bus.pad_out, 32'h61);
`else
    at_cyc(acc + 1);
    chk("rd_strb_pad_out", bus.pad_out, 32'h61);
    chk("rd_strb_oe", bus.pad_uio_oe, 32'h00);
`endif
    finish_txn();
    repeat (10) @(negedge clk);
    chk("rd_rdata_held", bus.cpu_rdata, 32'h7E);

    // A write leaves cpu_rdata alone; then a read at the top address.
    issue(11'h2F0, 1'b0, 8'h11, 8'h00, acc);
    finish_txn();
    issue(11'h7FF, 1'b1, 8'h00, 8'h81, acc);
    at_cyc(acc);
    chk("rd_top_ahi", {29'd0, bus.pad_out[2:0]}, 32'h7);
    chk("rd_top_uio", bus.pad_uio_out, 32'hFF);
    finish_txn();

    // Held request: back-to-back writes, each ack followed by one IDLE cycle.
    issue(11'h3C5, 1'b0, 8'h5A, 8'h00, acc);
    for (int k = 1; k <= 3; k++) begin
      exp_t e;
      e.rdata = last_rd;
      e.ack_cyc = acc + k * (LAT_WR + 1) + LAT_WR - 1;
      sb_q.push_back(e);
    end
    for (int k = 0; k <= 3; k++) begin
      at_cyc(acc + k * (LAT_WR + 1) + LAT_WR);
      chk("held_idle_busy", {31'd0, bus.pad_out[6]}, 32'd0);
      if (k == 3) begin
        bus.cpu_req = 1'b0;
      end else begin
        at_cyc(acc + (k + 1) * (LAT_WR + 1));
        chk("held_next_ale", {31'd0, bus.pad_out[3]}, 32'd1);
      end
    end
    repeat (5) @(negedge clk);
    chk("held_stopped_busy", {31'd0, bus.pad_out[6]}, 32'd0);

    // Reset in the middle of a write strobe.
    issue(11'h0AB, 1'b0, 8'hEE, 8'h00, acc);
    at_cyc(acc + 1);
    chk("mid_wr_strobe", {31'd0, bus.pad_out[5]}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pad_out", bus.pad_out, 32'h30);
    chk("mid_rst_oe", bus.pad_uio_oe, 32'h00);
    chk("mid_rst_ack", bus.cpu_ack, 32'h0);
    sb_q.delete();
    last_rd = 8'h00;
    bus.cpu_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_rdata", bus.cpu_rdata, 32'h00);

    // First request after reset starts normally.
    issue(11'h055, 1'b1, 8'h00, 8'h3C, acc);
    finish_txn();
    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule
